// File: rtl/clk_rst_gen.sv
// clk_rst_gen: divides clk_i into clk_o and releases an active-low downstream
//   reset (rst_no) after a fixed number of clk_o rising edges.
// Ports: clk_i (only clock), rst_i (async active-high reset), sw_rst_i (sync
//   software reset, present only with CLK_RST_GEN_SW_RST_EN defined),
//   clk_o (registered divided clock), rst_no (registered active-low reset).
// Config macro: CLK_RST_GEN_SW_RST_EN adds the sw_rst_i port; when it is not
//   defined the block behaves as if sw_rst_i were tied low.
// Latency: clk_o first rises on the 3rd clk_i edge after rst_i falls; rst_no
//   rises on the clk_o falling edge after the RstClkCycles-th clk_o rise.
// Backpressure: none; free-running once out of reset.

`timescale 1ns/1ps

module clk_rst_gen #(
   parameter int unsigned ClkDiv       = 4,  // clk_i cycles per clk_o period, 2..256
   parameter int unsigned RstClkCycles = 5   // clk_o rises before rst_no release, 1..65535
) (
   input  logic clk_i,
   input  logic rst_i,
`ifdef CLK_RST_GEN_SW_RST_EN
   input  logic sw_rst_i,
`endif
   output logic clk_o,
   output logic rst_no
);

   localparam int unsigned CntW  = $clog2(ClkDiv);
   localparam int unsigned EdgeW = $clog2(RstClkCycles + 1);

   localparam logic [CntW-1:0]  CntLast = CntW'(ClkDiv - 1);
   localparam logic [CntW-1:0]  CntHalf = CntW'(ClkDiv / 2);
   localparam logic [EdgeW-1:0] EdgeMax = EdgeW'(RstClkCycles);

   logic sw_rst;
`ifdef CLK_RST_GEN_SW_RST_EN
   assign sw_rst = sw_rst_i;
`else
   assign sw_rst = 1'b0;
`endif

   // Reset synchronizer: set asynchronously, cleared by shifting zeros in,
   // so the internal reset drops after the 2nd clk_i edge past rst_i release.
   logic [1:0] sync_q;
   logic       rst_sync;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], 1'b0};
      end
   end

   assign rst_sync = sync_q[1];

   logic [CntW-1:0]  cnt_q,  cnt_d;
   logic             clk_q,  clk_d;
   logic [EdgeW-1:0] edge_q, edge_d;
   logic             rstn_q, rstn_d;
   logic             hold;
   logic             clk_rise;
   logic             clk_fall;

   assign hold = rst_sync | sw_rst;

   // clk_o is a registered decode of the counter: it is high for the edges
   // that load cnt with 1..ClkDiv/2, so the first edge out of hold (cnt 0->1)
   // is a rising edge and the low phase absorbs the extra cycle of odd ratios.
   assign clk_rise = (cnt_q == '0);
   assign clk_fall = (cnt_q == CntHalf);

   always_comb begin
      cnt_d  = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
      clk_d  = (cnt_q < CntHalf);
      edge_d = edge_q;
      if (clk_rise && (edge_q != EdgeMax)) begin
         edge_d = edge_q + 1'b1;
      end
      // rst_no only ever rises together with a clk_o fall, then sticks.
      rstn_d = rstn_q | (clk_fall && (edge_q == EdgeMax));
      if (hold) begin
         cnt_d  = '0;
         clk_d  = 1'b0;
         edge_d = '0;
         rstn_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         clk_q  <= 1'b0;
         edge_q <= '0;
         rstn_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         clk_q  <= clk_d;
         edge_q <= edge_d;
         rstn_q <= rstn_d;
      end
   end

   assign clk_o  = clk_q;
   assign rst_no = rstn_q;

endmodule

// File: tb/tb_clk_rst_gen.sv
// Bench for clk_rst_gen: three instances (4/5, 5/5, 2/1) share clock and
// resets; a reference model tracks clk_i edges since reset release and
// derives the expected clk_o / rst_no waveforms arithmetically.

`timescale 1ns/1ps

module tb_clk_rst_gen;

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
`ifdef CLK_RST_GEN_SW_RST_EN
   logic sw = 1'b0;
`endif

   logic a_clk, a_rstn, b_clk, b_rstn, c_clk, c_rstn;

   clk_rst_gen #(.ClkDiv(4), .RstClkCycles(5)) u_a (
      .clk_i(clk_i), .rst_i(rst_i),
`ifdef CLK_RST_GEN_SW_RST_EN
      .sw_rst_i(sw),
`endif
      .clk_o(a_clk), .rst_no(a_rstn));

   clk_rst_gen #(.ClkDiv(5), .RstClkCycles(5)) u_b (
      .clk_i(clk_i), .rst_i(rst_i),
`ifdef CLK_RST_GEN_SW_RST_EN
      .sw_rst_i(sw),
`endif
      .clk_o(b_clk), .rst_no(b_rstn));

   clk_rst_gen #(.ClkDiv(2), .RstClkCycles(1)) u_c (
      .clk_i(clk_i), .rst_i(rst_i),
`ifdef CLK_RST_GEN_SW_RST_EN
      .sw_rst_i(sw),
`endif
      .clk_o(c_clk), .rst_no(c_rstn));

   always #5 clk_i = ~clk_i;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;
   int k      = 0;   // clk_i edges since reset release (edge 1 = first)
   logic pa = 1'b0, pb = 1'b0, pc = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input int exp);
      n_chk++;
      if (obs !== 32'(exp)) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (k=%0d, t=%0t)", tag, obs, exp, k, $time);
      end
   endtask

   // Expected clk_o after edge k: first rise at edge 3, then ClkDiv periodic,
   // high for ClkDiv/2 cycles.
   function automatic int exp_clk(input int kk, input int d);
      if (kk < 3) return 0;
      return (((kk - 3) % d) < (d / 2)) ? 1 : 0;
   endfunction

   // rst_no rises on the fall following the n-th rise: edge 3+(n-1)*d+d/2.
   function automatic int rise_edge(input int d, input int n);
      return 3 + (n - 1) * d + d / 2;
   endfunction

   function automatic int exp_rstn(input int kk, input int d, input int n);
      return (kk >= rise_edge(d, n)) ? 1 : 0;
   endfunction

   // Reference model: any rst_i assertion restarts the count; a sampled
   // software reset returns to the state right after synchronizer release.
   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         k <= 0;
`ifdef CLK_RST_GEN_SW_RST_EN
      end else if (sw) begin
         k <= (k + 1 < 2) ? k + 1 : 2;
`endif
      end else begin
         k <= k + 1;
      end
   end

   always @(negedge clk_i) begin
      if (chk_en) begin
         chk("a_clk",  a_clk,  exp_clk(k, 4));
         chk("a_rstn", a_rstn, exp_rstn(k, 4, 5));
         chk("b_clk",  b_clk,  exp_clk(k, 5));
         chk("b_rstn", b_rstn, exp_rstn(k, 5, 5));
         chk("c_clk",  c_clk,  exp_clk(k, 2));
         chk("c_rstn", c_rstn, exp_rstn(k, 2, 1));
         if (a_rstn === 1'b1 && pa === 1'b0) chk("a_rise_k", k, 21);
         if (b_rstn === 1'b1 && pb === 1'b0) chk("b_rise_k", k, 25);
         if (c_rstn === 1'b1 && pc === 1'b0) chk("c_rise_k", k, 4);
         pa = a_rstn;
         pb = b_rstn;
         pc = c_rstn;
      end
   end

   task automatic chk_async(input string tag);
      chk({tag, "_a_clk"},  a_clk,  0);
      chk({tag, "_a_rstn"}, a_rstn, 0);
      chk({tag, "_b_clk"},  b_clk,  0);
      chk({tag, "_b_rstn"}, b_rstn, 0);
      chk({tag, "_c_clk"},  c_clk,  0);
      chk({tag, "_c_rstn"}, c_rstn, 0);
   endtask

   // 3 ns rst_i pulse entirely between two clk_i edges.
   task automatic pulse_async();
      @(posedge clk_i);
      #1 rst_i = 1'b1;
      #1 chk_async("pulse");
      #2 rst_i = 1'b0;
   endtask

   task automatic hold_rst(input int n);
      @(negedge clk_i);
      #2 rst_i = 1'b1;
      #1 chk_async("hold");
      repeat (n) @(posedge clk_i);
      @(negedge clk_i);
      #2 rst_i = 1'b0;
   endtask

`ifdef CLK_RST_GEN_SW_RST_EN
   task automatic sw_pulse(input int w);
      @(negedge clk_i);
      #2 sw = 1'b1;
      repeat (w) @(posedge clk_i);
      #2 sw = 1'b0;
   endtask
`endif

   initial begin
      #1 rst_i = 1'b1;
      #1 chk_async("init");
      chk_en = 1'b1;
      // Reset held for 10 cycles, then the full ramp and 100+ periods of /5.
      repeat (10) @(posedge clk_i);
      @(negedge clk_i);
      #2 rst_i = 1'b0;
      repeat (560) @(posedge clk_i);

      // Short asynchronous pulse after rst_no is high.
      pulse_async();
      repeat (40) @(posedge clk_i);

      // Reassert after the 3rd clk_o rise of the /4 instance (edge 11).
      pulse_async();
      repeat (13) @(posedge clk_i);
      hold_rst(2);
      repeat (40) @(posedge clk_i);

`ifdef CLK_RST_GEN_SW_RST_EN
      sw_pulse(1);
      repeat (30) @(posedge clk_i);
`endif

      for (int i = 0; i < 12; i++) begin
         repeat ($urandom_range(1, 60)) @(posedge clk_i);
         case ($urandom_range(0, 2))
            0: pulse_async();
            1: hold_rst($urandom_range(1, 4));
            default: begin
`ifdef CLK_RST_GEN_SW_RST_EN
               sw_pulse($urandom_range(1, 3));
`else
               hold_rst(1);
`endif
            end
         endcase
      end
      repeat (40) @(posedge clk_i);
      @(negedge clk_i);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/clk_rst_gen.md
CLK_RST_GEN -- requirements
Module: clk_rst_gen

Interface
REQ-001 Parameter ClkDiv, default 4: clk_i cycles per clk_o period; legal range 2..256.
REQ-002 Parameter RstClkCycles, default 5: clk_o rising edges during which rst_no is held low after reset release; legal range 1..65535.
REQ-003 Port clk_i, input, 1: the only clock; all flops on its rising edge.
REQ-004 Port rst_i, input, 1: reset, asynchronous, active-high.
REQ-005 Port clk_o, output, 1: divided clock, registered.
REQ-006 Port rst_no, output, 1: active-low reset for downstream logic, registered.
REQ-007 Port sw_rst_i, input, 1: software reset request; exists only under CLK_RST_GEN_SW_RST_EN.

Function
REQ-008 Reset synchronizer:
- two flops; both set asynchronously on rst_i high.
- zero shifted in on each clk_i edge.
- internal rst_sync deasserts after the 2nd clk_i rising edge following rst_i low.
REQ-009 While rst_sync is high, hold: divider counter cnt = 0, clk_o = 0, edge counter = 0, rst_no = 0.
REQ-010 cnt counts 0..ClkDiv-1 on clk_i edges and wraps to 0; it first increments on the 1st edge after rst_sync release.
REQ-011 clk_o waveform:
- high for ClkDiv/2 clk_i cycles (integer division), then low for ClkDiv-ClkDiv/2 cycles.
- first rising edge occurs on the 1st clk_i edge after rst_sync release.
REQ-012 Edge counter:
- increments on each clk_o rising edge.
- saturates at RstClkCycles.
- width is $clog2(RstClkCycles+1).
REQ-013 When the edge counter has reached RstClkCycles, rst_no goes high on the same clk_i edge as the following clk_o falling edge; rst_no then stays high until the next reset.
REQ-014 clk_o and rst_no never change on different clk_i edges within the same clk_o phase; rst_no rises only coincident with a clk_o falling edge.
REQ-015 rst_i asserted mid-sequence (before or after rst_no high): immediate asynchronous return to REQ-009 values; the full sequence restarts on release.
REQ-016 Odd ClkDiv: the low phase is one cycle longer than the high phase; the period is exactly ClkDiv.

Reset
REQ-017 rst_i asserted: clk_o = 0 and rst_no = 0 asynchronously, no clock required.
REQ-018 No flop in the block is left without a reset value.

Configuration
REQ-019 Macro CLK_RST_GEN_SW_RST_EN.
- Defined: sw_rst_i is present and is sampled synchronously on clk_i. A high value resets cnt, clk_o, the edge counter and rst_no to REQ-009 values on the next edge and holds them while high. On release, the sequence restarts exactly as after rst_sync release.
- Not defined: port absent, behaviour identical to sw_rst_i tied low.

Verification
REQ-020 ClkDiv=4, RstClkCycles=5, rst_i high 10 cycles then low:
- clk_o first rises at the 3rd clk_i edge after release, period 4, high 2 cycles.
- rst_no rises at the 21st clk_i edge after release.
REQ-021 ClkDiv=5:
- clk_o high 2 cycles, low 3 cycles, period 5, for 100 periods.
- rst_no rises only on a clk_o falling edge.
REQ-022 rst_i pulsed high for 3 ns between clk_i edges after rst_no is high:
- clk_o and rst_no go to 0 immediately.
- sequence repeats identically to REQ-020 timing.
REQ-023 rst_i reasserted after the 3rd clk_o rising edge (rst_no still low): the counter restarts and rst_no still requires 5 fresh clk_o rising edges after release.
REQ-024 RstClkCycles=1, ClkDiv=2: rst_no rises at the 4th clk_i edge after rst_i release.
REQ-025 With CLK_RST_GEN_SW_RST_EN, sw_rst_i high for 1 cycle after rst_no is high:
- rst_no and clk_o are 0 after the next edge.
- rst_no rises 19 clk_i edges after sw_rst_i falls (ClkDiv=4, RstClkCycles=5).
